// File: rtl/tag_ring_pkg.sv
// Shared definitions for the tag_ring_sync slice: slot-state encoding and
// the round-robin pointer increment used by every ring pointer.
package tag_ring_pkg;

    typedef enum logic [1:0] {
        SLOT_FREE    = 2'd0,
        SLOT_LDMEM   = 2'd1,
        SLOT_COMPUTE = 2'd2,
        SLOT_STMEM   = 2'd3
    } slot_state_e;

    // Next pointer value, wrapping from depth-1 back to 0.
    function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned depth);
        return (ptr >= depth - 1) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/tag_ring_slot.sv
// One buffer slot of the tag ring: lifecycle state, pending-reuse counter and
// the two flags captured when the slot is freshly allocated.
module tag_ring_slot
    import tag_ring_pkg::*;
#(
    parameter int unsigned REUSE_W       = 4,
    parameter int unsigned STORE_ENABLED = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               alloc_i,
    input  logic               bias_i,
    input  logic               ddr_i,
    input  logic               reuse_i,
    input  logic               ld_done_i,
    input  logic               cmp_done_i,
    input  logic               st_done_i,
    output slot_state_e        state_o,
    output logic [REUSE_W-1:0] reuse_cnt_o,
    output logic               bias_o,
    output logic               ddr_o
);

    slot_state_e        state_q, state_d;
    logic [REUSE_W-1:0] cnt_q, cnt_d;
    logic               bias_q, bias_d;
    logic               ddr_q, ddr_d;

    // Slot lifecycle and reuse bookkeeping; a reuse and a non-final compute
    // done in the same cycle cancel out on the counter.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bias_d  = bias_q;
        ddr_d   = ddr_q;
        if (alloc_i) begin
            state_d = SLOT_LDMEM;
            bias_d  = bias_i;
            ddr_d   = ddr_i;
        end
        if (ld_done_i) begin
            state_d = SLOT_COMPUTE;
        end
        if (cmp_done_i) begin
            if (cnt_q != '0) begin
                cnt_d = cnt_q - REUSE_W'(1);
            end else begin
                state_d = (STORE_ENABLED != 0) ? SLOT_STMEM : SLOT_FREE;
            end
        end
        if (st_done_i) begin
            state_d = SLOT_FREE;
        end
        if (reuse_i) begin
            cnt_d = cnt_d + REUSE_W'(1);
        end
    end

    // Slot registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= SLOT_FREE;
            cnt_q   <= '0;
            bias_q  <= 1'b0;
            ddr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bias_q  <= bias_d;
            ddr_q   <= ddr_d;
        end
    end

    assign state_o     = state_q;
    assign reuse_cnt_o = cnt_q;
    assign bias_o      = bias_q;
    assign ddr_o       = ddr_q;

endmodule

// File: rtl/tag_ring_sync.sv
// N-deep buffer-tag synchronizer between the decoder and the ldmem, compute
// and stmem engines. Optional statistics counters are enabled by defining
// TAG_RING_STATS_EN.
module tag_ring_sync
    import tag_ring_pkg::*;
#(
    parameter int unsigned NUM_TAGS      = 4,
    parameter int unsigned TAG_W         = $clog2(NUM_TAGS),
    parameter int unsigned REUSE_W       = 4,
    parameter int unsigned STORE_ENABLED = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tag_req,
    input  logic             tag_reuse,
    input  logic             tag_bias_prev_sw,
    input  logic             tag_ddr_pe_sw,
    output logic             tag_ready,
    output logic [TAG_W-1:0] tag,
    output logic             tag_done,
    output logic [TAG_W:0]   occupancy,
    input  logic             ldmem_tag_done,
    output logic             ldmem_tag_ready,
    output logic [TAG_W-1:0] ldmem_tag,
    input  logic             compute_tag_done,
    output logic             compute_tag_ready,
    output logic [TAG_W-1:0] compute_tag,
    output logic             compute_bias_prev_sw,
    input  logic             stmem_tag_done,
    output logic             stmem_tag_ready,
    output logic [TAG_W-1:0] stmem_tag,
    output logic             stmem_ddr_pe_sw
`ifdef TAG_RING_STATS_EN
    ,
    output logic [31:0]      stall_alloc_cycles,
    output logic [31:0]      reuse_hits
`endif
);

    slot_state_e        slot_state [NUM_TAGS];
    logic [REUSE_W-1:0] slot_cnt   [NUM_TAGS];
    logic               slot_bias  [NUM_TAGS];
    logic               slot_ddr   [NUM_TAGS];

    logic [TAG_W-1:0] alloc_q, alloc_d, ld_q, ld_d, cmp_q, cmp_d, st_q, st_d;
    logic [TAG_W-1:0] prev_q, prev_d;
    logic             prev_valid_q, prev_valid_d;

    logic fresh_ready, reuse_ready, prev_busy;
    logic fresh_acc, reuse_acc, ld_acc, cmp_acc, cmp_final, st_acc;
    logic [TAG_W:0] occ_c;
    logic           pend_c;

    // Readiness is decoded from registered slot state at each pointer.
    assign fresh_ready       = (slot_state[alloc_q] == SLOT_FREE);
    assign ldmem_tag_ready   = (slot_state[ld_q] == SLOT_LDMEM);
    assign compute_tag_ready = (slot_state[cmp_q] == SLOT_COMPUTE);
    assign stmem_tag_ready   = (slot_state[st_q] == SLOT_STMEM);

    assign ld_acc    = ldmem_tag_done & ldmem_tag_ready;
    assign cmp_acc   = compute_tag_done & compute_tag_ready;
    assign cmp_final = cmp_acc & (slot_cnt[cmp_q] == '0);
    assign st_acc    = stmem_tag_done & stmem_tag_ready;

    assign prev_busy   = (slot_state[prev_q] == SLOT_LDMEM) || (slot_state[prev_q] == SLOT_COMPUTE);
    // A slot taking its final compute done this cycle cannot be reused.
    assign reuse_ready = prev_valid_q & prev_busy & (slot_cnt[prev_q] != '1)
                       & ~(cmp_final & (cmp_q == prev_q));

    assign tag_ready = tag_reuse ? reuse_ready : fresh_ready;
    assign tag       = tag_reuse ? prev_q : alloc_q;
    assign fresh_acc = tag_req & ~tag_reuse & fresh_ready;
    assign reuse_acc = tag_req & tag_reuse & reuse_ready;

    for (genvar i = 0; i < NUM_TAGS; i++) begin : g_slot
        localparam logic [TAG_W-1:0] IDX = TAG_W'(i);
        tag_ring_slot #(
            .REUSE_W      (REUSE_W),
            .STORE_ENABLED(STORE_ENABLED)
        ) u_slot (
            .clk        (clk),
            .reset      (reset),
            .alloc_i    (fresh_acc && (alloc_q == IDX)),
            .bias_i     (tag_bias_prev_sw),
            .ddr_i      (tag_ddr_pe_sw),
            .reuse_i    (reuse_acc && (prev_q == IDX)),
            .ld_done_i  (ld_acc && (ld_q == IDX)),
            .cmp_done_i (cmp_acc && (cmp_q == IDX)),
            .st_done_i  (st_acc && (st_q == IDX)),
            .state_o    (slot_state[i]),
            .reuse_cnt_o(slot_cnt[i]),
            .bias_o     (slot_bias[i]),
            .ddr_o      (slot_ddr[i])
        );
    end

    // Pointer and previous-tag next state; a fresh grant overrides the
    // prev_valid clear from a final compute in the same cycle.
    always_comb begin
        alloc_d      = alloc_q;
        ld_d         = ld_q;
        cmp_d        = cmp_q;
        st_d         = st_q;
        prev_d       = prev_q;
        prev_valid_d = prev_valid_q;
        if (cmp_final && (prev_q == cmp_q)) begin
            prev_valid_d = 1'b0;
        end
        if (fresh_acc) begin
            alloc_d      = TAG_W'(ptr_inc(32'(alloc_q), NUM_TAGS));
            prev_d       = alloc_q;
            prev_valid_d = 1'b1;
        end
        if (ld_acc) begin
            ld_d = TAG_W'(ptr_inc(32'(ld_q), NUM_TAGS));
        end
        if (cmp_final) begin
            cmp_d = TAG_W'(ptr_inc(32'(cmp_q), NUM_TAGS));
        end
        if (st_acc) begin
            st_d = TAG_W'(ptr_inc(32'(st_q), NUM_TAGS));
        end
    end

    // Pointer registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            alloc_q      <= '0;
            ld_q         <= '0;
            cmp_q        <= '0;
            st_q         <= '0;
            prev_q       <= '0;
            prev_valid_q <= 1'b0;
        end else begin
            alloc_q      <= alloc_d;
            ld_q         <= ld_d;
            cmp_q        <= cmp_d;
            st_q         <= st_d;
            prev_q       <= prev_d;
            prev_valid_q <= prev_valid_d;
        end
    end

    // Count busy slots and detect any pending reuse.
    always_comb begin
        occ_c  = '0;
        pend_c = 1'b0;
        for (int unsigned i = 0; i < NUM_TAGS; i++) begin
            if (slot_state[i] != SLOT_FREE) begin
                occ_c = occ_c + (TAG_W+1)'(1);
            end
            if (slot_cnt[i] != '0) begin
                pend_c = 1'b1;
            end
        end
    end

    assign occupancy            = occ_c;
    assign tag_done             = (occ_c == '0) & ~pend_c;
    assign ldmem_tag            = ld_q;
    assign compute_tag          = cmp_q;
    assign stmem_tag            = st_q;
    assign compute_bias_prev_sw = slot_bias[cmp_q];
    assign stmem_ddr_pe_sw      = slot_ddr[st_q];

`ifdef TAG_RING_STATS_EN
    logic [31:0] stall_q, stall_d, hits_q, hits_d;

    // Saturating stall and reuse-hit counters.
    always_comb begin
        stall_d = stall_q;
        hits_d  = hits_q;
        if (tag_req && !tag_ready && (stall_q != '1)) begin
            stall_d = stall_q + 32'd1;
        end
        if (reuse_acc && (hits_q != '1)) begin
            hits_d = hits_q + 32'd1;
        end
    end

    // Statistics registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_q <= '0;
            hits_q  <= '0;
        end else begin
            stall_q <= stall_d;
            hits_q  <= hits_d;
        end
    end

    assign stall_alloc_cycles = stall_q;
    assign reuse_hits         = hits_q;
`endif

endmodule
